request_latch: RTL and testbench

REQUEST_LATCH -- requirements
Module: request_latch

---
 rtl/request_latch.sv | 159 +++++++++++++++
 tb/tb_request_latch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/request_latch.sv
// Debounces the walk, sensor and reprogram inputs, then latches walk requests
// through a pending/serving handshake and raises reprogram strobes until acknowledged.
module request_latch #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       WR_Sync,
  input  logic       Sensor_Sync,
  input  logic       Prog_Sync,
  input  logic       WR_Ack,
  input  logic       Prog_Ack,
  output logic       Walk_Req,
  output logic       Sensor_Level,
  output logic       Prog_Pulse,
  output logic       Prog_Pending,
  output logic [7:0] WR_Count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_SERVING = 2'd2
  } state_t;

  // bit 0 walk, bit 1 sensor, bit 2 prog
  logic [2:0]    w_raw;
  logic [2:0]    r_filt;
  logic [CW-1:0] r_cnt [3];
  logic          r_prev_walk;
  logic          r_prev_prog;
  logic          w_walk_edge;
  logic          w_prog_edge;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_queued;
  logic          w_next_queued;
  logic          w_count_inc;
  logic          w_walk_req_nxt;
  logic          w_prog_pend_nxt;
  logic [7:0]    w_count_nxt;

  assign w_raw        = {Prog_Sync, Sensor_Sync, WR_Sync};
  assign w_walk_edge  = r_filt[0] & ~r_prev_walk;
  assign w_prog_edge  = r_filt[2] & ~r_prev_prog;
  assign Sensor_Level = r_filt[1];

  // Debounce filters: a value is accepted after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_filt <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= C_ZERO;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_raw[i] != r_filt[i]) begin
          if (r_cnt[i] == C_LAST) begin
            r_filt[i] <= w_raw[i];
            r_cnt[i]  <= C_ZERO;
          end else begin
            r_cnt[i]  <= r_cnt[i] + C_ONE;
          end
        end else begin
          r_cnt[i] <= C_ZERO;
        end
      end
    end
  end

  // State, edge history and registered outputs.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_queued     <= 1'b0;
      r_prev_walk  <= 1'b0;
      r_prev_prog  <= 1'b0;
      Walk_Req     <= 1'b0;
      Prog_Pulse   <= 1'b0;
      Prog_Pending <= 1'b0;
      WR_Count     <= 8'd0;
    end else begin
      r_state      <= w_next_state;
      r_queued     <= w_next_queued;
      r_prev_walk  <= r_filt[0];
      r_prev_prog  <= r_filt[2];
      Walk_Req     <= w_walk_req_nxt;
      Prog_Pulse   <= w_prog_edge;
      Prog_Pending <= w_prog_pend_nxt;
      WR_Count     <= w_count_nxt;
    end
  end

  // Walk handshake next-state; an edge coincident with ack release still counts as queued.
  always_comb begin
    w_next_state  = r_state;
    w_next_queued = r_queued;
    case (r_state)
      S_IDLE: begin
        if (w_walk_edge) begin
          w_next_state = S_PENDING;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_PENDING: begin
        if (WR_Ack) begin
          w_next_state  = S_SERVING;
          w_next_queued = w_walk_edge;
        end else begin
          w_next_state  = S_PENDING;
        end
      end
      S_SERVING: begin
        if (!WR_Ack) begin
          w_next_state  = (r_queued | w_walk_edge) ? S_PENDING : S_IDLE;
          w_next_queued = 1'b0;
        end else begin
          w_next_queued = r_queued | w_walk_edge;
        end
      end
      default: begin
        w_next_state  = S_IDLE;
        w_next_queued = 1'b0;
      end
    endcase
  end

  // Output decode: request level, saturating accepted-edge count, prog pending flag.
  always_comb begin
    w_count_inc = 1'b0;
    case (r_state)
      S_IDLE:    w_count_inc = w_walk_edge;
      S_PENDING: w_count_inc = w_walk_edge & WR_Ack;
      S_SERVING: w_count_inc = w_walk_edge & ~r_queued;
      default:   w_count_inc = 1'b0;
    endcase
    w_walk_req_nxt = (w_next_state == S_PENDING);
    if (w_count_inc && (WR_Count != 8'hFF)) begin
      w_count_nxt = WR_Count + 8'd1;
    end else begin
      w_count_nxt = WR_Count;
    end
    if (w_prog_edge) begin
      w_prog_pend_nxt = 1'b1;
    end else if (Prog_Ack) begin
      w_prog_pend_nxt = 1'b0;
    end else begin
      w_prog_pend_nxt = Prog_Pending;
    end
  end

endmodule

// File: tb/tb_request_latch.sv
// Self-checking bench for request_latch: vector table, directed corner sequences
// and randomized stimulus checked against a behavioural model.
module tb_request_latch;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       Reset;
  logic       wr, sens, prog, wrack, pack;
  logic       Walk_Req, Sensor_Level, Prog_Pulse, Prog_Pending;
  logic [7:0] WR_Count;

  int n_cmp = 0;
  int n_bad = 0;

  request_latch #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .Reset(Reset),
    .WR_Sync(wr), .Sensor_Sync(sens), .Prog_Sync(prog),
    .WR_Ack(wrack), .Prog_Ack(pack),
    .Walk_Req(Walk_Req), .Sensor_Level(Sensor_Level), .Prog_Pulse(Prog_Pulse),
    .Prog_Pending(Prog_Pending), .WR_Count(WR_Count)
  );

  always #5 clk = ~clk;

  // Behavioural model: request bookkeeping as plain flags and integers.
  bit m_f[3];
  int m_run[3];
  bit m_seen_w, m_seen_p;
  bit m_waiting, m_in_service, m_second_press;
  bit m_pulse, m_pend;
  int m_count;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin m_f[i] = 1'b0; m_run[i] = 0; end
    m_seen_w = 1'b0; m_seen_p = 1'b0;
    m_waiting = 1'b0; m_in_service = 1'b0; m_second_press = 1'b0;
    m_pulse = 1'b0; m_pend = 1'b0; m_count = 0;
  endfunction

  function automatic void model_step(input bit [2:0] raw, input bit ack, input bit pa);
    bit press, pgm;
    press = m_f[0] && !m_seen_w;
    pgm   = m_f[2] && !m_seen_p;
    m_seen_w = m_f[0];
    m_seen_p = m_f[2];
    for (int i = 0; i < 3; i++) begin
      if (raw[i] != m_f[i]) begin
        m_run[i]++;
        if (m_run[i] == N) begin m_f[i] = raw[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
    if (m_in_service) begin
      if (press && !m_second_press) begin m_second_press = 1'b1; m_count++; end
      if (!ack) begin m_in_service = 1'b0; m_waiting = m_second_press; m_second_press = 1'b0; end
    end else if (m_waiting) begin
      if (ack) begin
        m_waiting = 1'b0; m_in_service = 1'b1;
        if (press) begin m_second_press = 1'b1; m_count++; end
      end
    end else if (press) begin
      m_waiting = 1'b1; m_count++;
    end
    if (m_count > 255) m_count = 255;
    m_pulse = pgm;
    if (pgm) m_pend = 1'b1;
    else if (pa) m_pend = 1'b0;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {4'd0, Walk_Req, Sensor_Level, Prog_Pulse, Prog_Pending, WR_Count};
  endfunction

  // One clock: sample inputs, advance model, compare after the edge.
  task automatic tick();
    bit [2:0] raw;
    bit a, pa;
    logic [7:0] mc;
    raw = {prog, sens, wr};
    a = wrack; pa = pack;
    @(posedge clk);
    model_step(raw, a, pa);
    #1;
    mc = m_count[7:0];
    check("model", dut_vec(), {4'd0, m_waiting, m_f[1], m_pulse, m_pend, mc});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    bit wr, sens, prog, ack, pack;
    bit e_walk, e_sens, e_pulse, e_pend;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[21];

  initial begin
    // wr/prog press then serve; sensor debounce; 3-cycle walk glitch
    for (int i = 0; i < 4; i++) tbl[i] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'd0};
    tbl[4] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b1, 8'd1};
    tbl[5] = '{1'b1,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 8'd1};
    tbl[6] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'd1};
    for (int i = 7; i < 12; i++) tbl[i] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'd1};
    for (int i = 12; i < 15; i++) tbl[i] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'd1};
    tbl[15] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 8'd1};
    for (int i = 16; i < 19; i++) tbl[i] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 8'd1};
    for (int i = 19; i < 21; i++) tbl[i] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 8'd1};

    Reset = 1'b0; wr = 1'b0; sens = 1'b0; prog = 1'b0; wrack = 1'b0; pack = 1'b0;
    model_reset();
    #12;
    check("reset_state", dut_vec(), 16'h0000);
    @(negedge clk); Reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      wr = tbl[i].wr; sens = tbl[i].sens; prog = tbl[i].prog;
      wrack = tbl[i].ack; pack = tbl[i].pack;
      tick();
      check($sformatf("vec%0d", i), dut_vec(),
            {4'd0, tbl[i].e_walk, tbl[i].e_sens, tbl[i].e_pulse, tbl[i].e_pend, tbl[i].e_cnt});
    end

    // second press debounced while being served, then ack drops
    wr = 1'b1; ticks(5);
    check("press_req", {15'd0, Walk_Req}, 16'd1);
    check("press_cnt", {8'd0, WR_Count}, 16'd2);
    wrack = 1'b1; wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) wr = 1'b1;
      tick();
      check("req_during_ack", {15'd0, Walk_Req}, 16'd0);
    end
    wrack = 1'b0; tick();
    check("req_after_ack", {15'd0, Walk_Req}, 16'd1);
    check("cnt_after_ack", {8'd0, WR_Count}, 16'd3);
    wrack = 1'b1; tick(); wrack = 1'b0; tick();
    check("served_idle", {15'd0, Walk_Req}, 16'd0);
    wr = 1'b0; ticks(5);

    // press edge coincident with ack in pending
    wr = 1'b1; ticks(5); wr = 1'b0; ticks(5); wr = 1'b1; ticks(4);
    wrack = 1'b1; tick();
    check("coinc_req", {15'd0, Walk_Req}, 16'd0);
    check("coinc_cnt", {8'd0, WR_Count}, 16'd5);
    wrack = 1'b0; tick();
    check("coinc_requeue", {15'd0, Walk_Req}, 16'd1);
    wrack = 1'b1; tick(); wrack = 1'b0; wr = 1'b0; ticks(5);

    // saturation
    for (int k = 0; k < 300; k++) begin
      wr = 1'b1; ticks(5); wrack = 1'b1; tick(); wrack = 1'b0; wr = 1'b0; ticks(5);
    end
    check("count_sat", {8'd0, WR_Count}, 16'd255);

    // async reset mid-handshake with inputs held high
    wr = 1'b1; prog = 1'b1; ticks(5);
    check("pre_reset", {14'd0, Walk_Req, Prog_Pending}, 16'd3);
    #2 Reset = 1'b0;
    #1 check("async_reset", dut_vec(), 16'h0000);
    model_reset();
    #1 Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_reset_quiet", dut_vec(), 16'h0000);
    end
    tick();
    check("post_reset_req", dut_vec(), {4'd0, 4'b1011, 8'd1});
    pack = 1'b1; wrack = 1'b1; tick();
    pack = 1'b0; wrack = 1'b0;

    // randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) wr = ~wr;
      if ($urandom_range(5) == 0) sens = ~sens;
      if ($urandom_range(5) == 0) prog = ~prog;
      if ($urandom_range(4) == 0) wrack = ~wrack;
      pack = ($urandom_range(3) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
